iot_riscv_irq_arb: RTL
======================

IOT_RISCV_IRQ_ARB -- requirements
Module: iot_riscv_irq_arb

Interface
REQ-001 SHALL have parameter irq_width_p, default 32: number of interrupt sources, legal range 2..32.
REQ-002 SHALL derive localparam id_width_p = $clog2(irq_width_p): width of a source index.
REQ-003 SHALL have port main_clk_i, input, 1: the single clock.
REQ-004 SHALL have port main_rst_i, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port src_i, input, irq_width_p: raw interrupt sources, synchronous to main_clk_i.
REQ-006 SHALL have port edge_i, input, irq_width_p: per-source mode, 1 = rising-edge, 0 = level.
REQ-007 SHALL have port en_i, input, irq_width_p: per-source enable.
REQ-008 SHALL have port clr_i, input, irq_width_p: per-source software clear of pending, one-cycle pulse.
REQ-009 SHALL have port id_irq_i, input, 1: core accepted trap this cycle.
REQ-010 SHALL have port id_mret_i, input, 1: core executed mret this cycle.
REQ-011 SHALL have port core_irq_o, output, 1: request line to the core interrupt indicator.
REQ-012 SHALL have port claim_vld_o, output, 1: a source is in service.
REQ-013 SHALL have port claim_id_o, output, id_width_p: index of the in-service source.
REQ-014 SHALL have port pend_o, output, irq_width_p: pending vector.

Function
REQ-015 SHALL register src_i into src_q every cycle; edge event = src_i & ~src_q.
REQ-016 Edge-mode source: pending SHALL set on edge event, clear on clr_i or on claim of that source; set SHALL win over a same-cycle clear.
REQ-017 Level-mode source: pending SHALL equal registered src_i; clr_i and claim SHALL have no effect on it.
REQ-018 Eligible vector SHALL be pend & en_i; winner SHALL be the lowest-index eligible bit, computed combinationally.
REQ-019 FSM states SHALL be IDLE, REQ and SERVE, state-encoded in a 2-bit register.
REQ-020 IDLE: if any eligible, SHALL go to REQ next cycle.
REQ-021 REQ: core_irq_o SHALL be 1; if no eligible remains, SHALL return to IDLE with no claim.
REQ-022 REQ: on id_irq_i, SHALL latch the current winner into claim_id_o, clear its pending (edge mode), and go to SERVE.
REQ-023 SERVE: claim_vld_o SHALL be 1 and core_irq_o SHALL be 0; claim_id_o SHALL be stable.
REQ-024 SERVE: new edges SHALL still set pending, including on the in-service source.
REQ-025 SERVE: on id_mret_i, SHALL go to IDLE; REQ SHALL not be re-entered in that same cycle, giving a minimum one-cycle gap.
REQ-026 id_irq_i in IDLE or SERVE, and id_mret_i in IDLE or REQ, SHALL be ignored.
REQ-027 If id_irq_i and id_mret_i are asserted together in REQ, id_irq_i SHALL take priority.
REQ-028 Latency SHALL be 2 cycles from a source edge to core_irq_o (pending register, then FSM).

Reset
REQ-029 While main_rst_i is high, all of the following SHALL hold, including mid-service: state IDLE, src_q 0, pend_o 0, core_irq_o 0, claim_vld_o 0, claim_id_o 0.
REQ-030 On release of main_rst_i, a source already high SHALL not produce an edge event in the first cycle.

Structure
REQ-031 The FSM state enum and id_width_p helper SHALL reside in package iot_riscv_irq_pkg.
REQ-032 The lowest-index priority encoder SHALL be sub-module iot_riscv_irq_prio_enc (vector in, valid/index out).

Verification
REQ-033 src_i[5] rising edge, edge_i[5]=1, en_i[5]=1 -> pend_o[5]=1 at +1 cycle, core_irq_o=1 at +2; id_irq_i -> claim_id_o=5, claim_vld_o=1, pend_o[5]=0.
REQ-034 pend bits 3 and 9 set together, both enabled -> claim_id_o=3; after id_mret_i, one idle cycle, then core_irq_o=1 again and next claim_id_o=9.
REQ-035 Level source 2 in REQ drops before id_irq_i -> FSM returns to IDLE, claim_vld_o stays 0.
REQ-036 Edge on source 4 and clr_i[4] in the same cycle -> pend_o[4]=1.
REQ-037 main_rst_i pulsed in SERVE -> all outputs 0 next cycle; src_i held high through release -> no pending in edge mode.
REQ-038 id_irq_i and id_mret_i asserted together in REQ -> go to SERVE with a claim.

Source files
------------

// File: rtl/iot_riscv_irq_pkg.sv
// Shared types for the RISC-V interrupt arbiter: FSM state encoding and
// the source-index width helper.
package iot_riscv_irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REQ   = 2'b01,
        ST_SERVE = 2'b10
    } irq_state_e;

    function automatic int irq_id_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/iot_riscv_irq_prio_enc.sv
// Lowest-index-first priority encoder: reports whether any bit is set and
// the index of the lowest set bit.
module iot_riscv_irq_prio_enc #(
    parameter int width_p     = 32,
    parameter int idx_width_p = 5
) (
    input  logic [width_p-1:0]     vec,
    output logic                   vld,
    output logic [idx_width_p-1:0] idx
);

    // scan from the top so the lowest set bit is the last to write idx
    always_comb begin
        vld = 1'b0;
        idx = {idx_width_p{1'b0}};
        for (int i = width_p - 1; i >= 0; i--) begin
            idx = vec[i] ? idx_width_p'(i) : idx;
            vld = vld | vec[i];
        end
    end

endmodule

// File: rtl/iot_riscv_irq_arb.sv
// Interrupt arbiter: per-source edge/level pending capture, lowest-index
// arbitration and a request/serve handshake with the core.
module iot_riscv_irq_arb
    import iot_riscv_irq_pkg::*;
#(
    parameter  int irq_width_p = 32,
    localparam int id_width_p  = irq_id_width(irq_width_p)
) (
    input  logic                   main_clk_i,
    input  logic                   main_rst_i,
    input  logic [irq_width_p-1:0] src_i,
    input  logic [irq_width_p-1:0] edge_i,
    input  logic [irq_width_p-1:0] en_i,
    input  logic [irq_width_p-1:0] clr_i,
    input  logic                   id_irq_i,
    input  logic                   id_mret_i,
    output logic                   core_irq_o,
    output logic                   claim_vld_o,
    output logic [id_width_p-1:0]  claim_id_o,
    output logic [irq_width_p-1:0] pend_o
);

    localparam logic [irq_width_p-1:0] zero_c = {irq_width_p{1'b0}};
    localparam logic [irq_width_p-1:0] one_c  = {{(irq_width_p-1){1'b0}}, 1'b1};

    irq_state_e               state_r;
    irq_state_e               state_nxt_s;
    logic [irq_width_p-1:0]   src_q_r;
    logic [irq_width_p-1:0]   pend_r;
    logic [irq_width_p-1:0]   pend_nxt_s;
    logic [irq_width_p-1:0]   edge_evt_s;
    logic [irq_width_p-1:0]   elig_s;
    logic [irq_width_p-1:0]   claim_mask_s;
    logic                     armed_r;
    logic                     win_vld_s;
    logic [id_width_p-1:0]    win_id_s;
    logic                     claim_s;
    logic                     core_irq_r;
    logic                     claim_vld_r;
    logic [id_width_p-1:0]    claim_id_r;

    // armed_r masks the first cycle after reset so a source already high is not seen as an edge
    assign edge_evt_s   = armed_r ? (src_i & ~src_q_r) : zero_c;
    assign elig_s       = pend_r & en_i;
    assign claim_mask_s = claim_s ? (one_c << win_id_s) : zero_c;

    iot_riscv_irq_prio_enc #(
        .width_p     (irq_width_p),
        .idx_width_p (id_width_p)
    ) u_prio_enc (
        .vec (elig_s),
        .vld (win_vld_s),
        .idx (win_id_s)
    );

    // next pending: edge sources latch events (set beats clear), level sources follow src
    always_comb begin
        pend_nxt_s = zero_c;
        for (int i = 0; i < irq_width_p; i++) begin
            if (edge_i[i]) begin
                pend_nxt_s[i] = edge_evt_s[i] | (pend_r[i] & ~clr_i[i] & ~claim_mask_s[i]);
            end else begin
                pend_nxt_s[i] = src_i[i];
            end
        end
    end

    // FSM next state and claim strobe
    always_comb begin
        state_nxt_s = state_r;
        claim_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (win_vld_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!win_vld_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (id_irq_i) begin
                    state_nxt_s = ST_SERVE;
                    claim_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_SERVE: begin
                if (id_mret_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SERVE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // source sampling, pending vector and first-cycle arming
    always_ff @(posedge main_clk_i or posedge main_rst_i) begin
        if (main_rst_i) begin
            src_q_r <= zero_c;
            pend_r  <= zero_c;
            armed_r <= 1'b0;
        end else begin
            src_q_r <= src_i;
            pend_r  <= pend_nxt_s;
            armed_r <= 1'b1;
        end
    end

    // FSM state and registered handshake outputs
    always_ff @(posedge main_clk_i or posedge main_rst_i) begin
        if (main_rst_i) begin
            state_r     <= ST_IDLE;
            core_irq_r  <= 1'b0;
            claim_vld_r <= 1'b0;
            claim_id_r  <= {id_width_p{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            core_irq_r  <= (state_nxt_s == ST_REQ);
            claim_vld_r <= (state_nxt_s == ST_SERVE);
            if (claim_s) begin
                claim_id_r <= win_id_s;
            end else begin
                claim_id_r <= claim_id_r;
            end
        end
    end

    assign core_irq_o  = core_irq_r;
    assign claim_vld_o = claim_vld_r;
    assign claim_id_o  = claim_id_r;
    assign pend_o      = pend_r;

endmodule
